// File: rtl/vliw_bundle_fetch.sv
// vliw_bundle_fetch: in-order fetch of VLIW bundles from a 1-cycle synchronous
// instruction memory into a 2-entry output buffer, with valid/ready backpressure,
// PC redirect/flush, halt on an accepted all-zero bundle, and a per-slot NOP mask.
module vliw_bundle_fetch #(
    parameter int SLOTS        = 10,
    parameter int SLOT_W       = 32,
    parameter int BUNDLE_W     = SLOTS * SLOT_W,
    parameter int ADDR_W       = 32,
    parameter int IMEM_DEPTH   = 1024,
    parameter int HALT_ON_ZERO = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_imem_en,
    output logic [ADDR_W-1:0]   o_imem_addr,
    input  logic [BUNDLE_W-1:0] i_imem_rdata,
    input  logic                i_redirect_valid,
    input  logic [ADDR_W-1:0]   i_redirect_pc,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [BUNDLE_W-1:0] o_out_bundle,
    output logic [ADDR_W-1:0]   o_out_pc,
    output logic [SLOTS-1:0]    o_out_slot_valid,
    output logic                o_halted,
    output logic                o_fetch_err
);

    localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(IMEM_DEPTH);

    typedef enum logic {S_RUN, S_HALTED} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_run;

    logic [ADDR_W-1:0]   r_pc;
    logic                r_pend;
    logic [ADDR_W-1:0]   r_pend_pc;
    logic [1:0]          r_count;
    logic [BUNDLE_W-1:0] r_buf_data [2];
    logic [ADDR_W-1:0]   r_buf_pc   [2];
    logic                r_fetch_err;

    logic                w_pop;
    logic [2:0]          w_occ;
    logic                w_issue;
    logic                w_halt;
    logic                w_flush;
    logic                w_wr;
    logic [1:0]          w_tail;
    logic                w_oor;

    // Buffer slots occupied once this cycle's pop retires and the in-flight read lands
    assign w_pop   = o_out_valid && i_out_ready;
    assign w_occ   = {1'b0, r_count} + {2'b0, r_pend} - {2'b0, w_pop};
    assign w_issue = w_run && !i_redirect_valid && !i_rst && (w_occ < 3'd2);

    // A redirect overrides a simultaneous halting transfer
    assign w_halt  = w_pop && (r_buf_data[0] == '0) && (HALT_ON_ZERO != 0) && !i_redirect_valid;
    assign w_flush = i_redirect_valid || w_halt;
    assign w_wr    = r_pend && !w_flush;
    assign w_tail  = r_count - {1'b0, w_pop};
    assign w_oor   = ({1'b0, i_redirect_pc} >= DEPTH_EXT);

    assign o_imem_en   = w_issue;
    assign o_imem_addr = r_pc;
    assign o_out_valid = (r_count != 2'd0);
    assign o_out_bundle = o_out_valid ? r_buf_data[0] : '0;
    assign o_out_pc     = o_out_valid ? r_buf_pc[0]   : '0;
    assign o_fetch_err  = r_fetch_err;

    genvar g;
    generate
        for (g = 0; g < SLOTS; g++) begin : g_slot
            assign o_out_slot_valid[g] = |o_out_bundle[g*SLOT_W +: SLOT_W];
        end
    endgenerate

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: halt on accepted zero bundle, resume on redirect
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:    if (w_halt)           w_state_nxt = S_HALTED;
            S_HALTED: if (i_redirect_valid) w_state_nxt = S_RUN;
            default:                        w_state_nxt = S_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_run    = (r_state == S_RUN);
        o_halted = (r_state == S_HALTED);
    end

    // PC, outstanding read tracking and sticky range error
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc        <= '0;
            r_pend      <= 1'b0;
            r_pend_pc   <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_pend    <= w_issue && !w_flush;
            r_pend_pc <= r_pc;
            if (i_redirect_valid) begin
                r_pc <= w_oor ? '0 : i_redirect_pc;
                if (w_oor) r_fetch_err <= 1'b1;
            end else if (w_issue) begin
                r_pc <= (r_pc == LAST_PC) ? '0 : r_pc + 1'b1;
            end
        end
    end

    // Occupancy count of the 2-entry output buffer
    always_ff @(posedge i_clk) begin
        if (i_rst)        r_count <= 2'd0;
        else if (w_flush) r_count <= 2'd0;
        else              r_count <= r_count + {1'b0, w_wr} - {1'b0, w_pop};
    end

    // Buffer storage: shift head on pop, land read data at the post-pop tail
    always_ff @(posedge i_clk) begin
        if (w_pop && r_count == 2'd2) begin
            r_buf_data[0] <= r_buf_data[1];
            r_buf_pc[0]   <= r_buf_pc[1];
        end
        if (w_wr) begin
            if (w_tail == 2'd0) begin
                r_buf_data[0] <= i_imem_rdata;
                r_buf_pc[0]   <= r_pend_pc;
            end else begin
                r_buf_data[1] <= i_imem_rdata;
                r_buf_pc[1]   <= r_pend_pc;
            end
        end
    end

endmodule

// File: tb/tb_vliw_bundle_fetch.sv
// Bench for vliw_bundle_fetch: a 16-bundle memory model, a scoreboard queue of
// expected bundle indices checked on every transfer, and per-scenario tasks.
module tb_vliw_bundle_fetch;
    localparam int SLOTS = 10, SLOT_W = 32, BW = 320, AW = 32, DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_en;
    logic [AW-1:0]   imem_addr;
    logic [BW-1:0]   imem_rdata = '0;
    logic            redirect_valid = 1'b0;
    logic [AW-1:0]   redirect_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BW-1:0]   out_bundle;
    logic [AW-1:0]   out_pc;
    logic [SLOTS-1:0] out_slot_valid;
    logic            halted;
    logic            fetch_err;

    logic [BW-1:0]   mem [DEPTH];
    int              exp_q[$];
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    vliw_bundle_fetch #(.SLOTS(SLOTS), .SLOT_W(SLOT_W), .BUNDLE_W(BW), .ADDR_W(AW),
                        .IMEM_DEPTH(DEPTH), .HALT_ON_ZERO(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_en(imem_en), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
        .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_bundle(out_bundle), .o_out_pc(out_pc), .o_out_slot_valid(out_slot_valid),
        .o_halted(halted), .o_fetch_err(fetch_err));

    // instruction memory: 1-cycle synchronous read
    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr[3:0]];

    function automatic logic [BW-1:0] mk(input int i);
        logic [BW-1:0] b;
        for (int s = 0; s < SLOTS; s++)
            b[s*SLOT_W +: SLOT_W] = ((i + s) % 3 == 0) ? 32'h0 : (32'hA000_0000 | (32'(i) << 8) | 32'(s));
        return b;
    endfunction

    function automatic logic [SLOTS-1:0] mask_of(input logic [BW-1:0] b);
        logic [SLOTS-1:0] m;
        for (int s = 0; s < SLOTS; s++) m[s] = (b[s*SLOT_W +: SLOT_W] != 32'h0);
        return m;
    endfunction

    // scoreboard: every transfer must match the next expected index and its bundle
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: unexpected out_pc=%0d, required no transfer", out_pc);
            end else begin
                int p;
                p = exp_q.pop_front();
                if (out_pc !== AW'(p) || out_bundle !== mem[p] || out_slot_valid !== mask_of(mem[p])) begin
                    errors++;
                    $display("FAIL sb_xfer: out_pc=%0d mask=%b bundle=%h, required pc=%0d mask=%b bundle=%h",
                             out_pc, out_slot_valid, out_bundle, p, mask_of(mem[p]), mem[p]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d bundles left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (imem_en !== 1'b0 || imem_addr !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: en=%b addr=%0d valid=%b, required 0 0 0", imem_en, imem_addr, out_valid);
        end
        checks++;
        if (out_bundle !== '0 || out_pc !== '0 || out_slot_valid !== '0 || halted !== 1'b0 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: pc=%0d mask=%b halted=%b err=%b, required all 0", out_pc, out_slot_valid, halted, fetch_err);
        end
    endtask

    task automatic test_latency_halt;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) exp_q.push_back(k);
        tick(); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== '0) begin
            errors++;
            $display("FAIL lat_issue: en=%b addr=%0d, required 1 0", imem_en, imem_addr);
        end
        tick(); @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_n1: out_valid=%b, required 0", out_valid);
        end
        for (int k = 0; k < 5; k++) begin
            tick(); @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== AW'(k)) begin
                errors++;
                $display("FAIL b2b: valid=%b pc=%0d, required 1 %0d", out_valid, out_pc, k);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick(); @(negedge clk);
            checks++;
            if (halted !== 1'b1 || out_valid !== 1'b0 || imem_en !== 1'b0) begin
                errors++;
                $display("FAIL halt: halted=%b valid=%b en=%b, required 1 0 0", halted, out_valid, imem_en);
            end
        end
    endtask

    task automatic test_slot_mask;
        tick(); redirect_valid = 1'b1; redirect_pc = 8; out_ready = 1'b1;
        exp_q.push_back(8); exp_q.push_back(9);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 32'd8 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL resume: halted=%b en=%b addr=%0d valid=%b, required 0 1 8 0", halted, imem_en, imem_addr, out_valid);
        end
        tick(); tick(); @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'd8 || out_slot_valid !== 10'b0000100000) begin
            errors++;
            $display("FAIL slot_mask: valid=%b pc=%0d mask=%b, required 1 8 0000100000", out_valid, out_pc, out_slot_valid);
        end
        drain(10);
        tick(); @(negedge clk);
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL slot_halt: halted=%b, required 1", halted);
        end
    endtask

    task automatic test_backpressure;
        tick(); redirect_valid = 1'b1; redirect_pc = 0; out_ready = 1'b0;
        tick(); redirect_valid = 1'b0;
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== '0 || out_bundle !== mem[0] || imem_en !== 1'b0) begin
                errors++;
                $display("FAIL stall: valid=%b pc=%0d en=%b, required 1 0 0", out_valid, out_pc, imem_en);
            end
        end
        for (int k = 0; k < 5; k++) exp_q.push_back(k);
        tick(); out_ready = 1'b1;
        drain(20);
        tick(); tick(); @(negedge clk);
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL bp_halt: halted=%b, required 1", halted);
        end
    endtask

    task automatic test_redirect_pending;
        tick(); redirect_valid = 1'b1; redirect_pc = 0; out_ready = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1);
        tick(); redirect_valid = 1'b0;
        tick(); tick(); @(negedge clk);
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 32'd2) begin
            errors++;
            $display("FAIL rd_issue2: en=%b addr=%0d, required 1 2", imem_en, imem_addr);
        end
        tick(); redirect_valid = 1'b1; redirect_pc = 7;
        exp_q.push_back(7); exp_q.push_back(8); exp_q.push_back(9);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'd1) begin
            errors++;
            $display("FAIL rd_xfer: valid=%b pc=%0d, required 1 1", out_valid, out_pc);
        end
        tick(); redirect_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) tick();
            @(negedge clk);
            checks++;
            if (out_valid !== (k == 3) || (k == 3 && out_pc !== 32'd7)) begin
                errors++;
                $display("FAIL rd_lat R+%0d: valid=%b pc=%0d, required %b 7", k, out_valid, out_pc, k == 3);
            end
        end
        drain(10);
        tick(); tick(); @(negedge clk);
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL rd_halt: halted=%b, required 1", halted);
        end
    endtask

    task automatic test_wrap_err;
        tick(); redirect_valid = 1'b1; redirect_pc = 14; out_ready = 1'b1;
        exp_q = '{14, 15, 0, 1, 2, 3, 4};
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_err0: fetch_err=%b, required 0", fetch_err);
        end
        drain(20);
        tick(); tick();
        tick(); redirect_valid = 1'b1; redirect_pc = 20;
        exp_q = '{0, 1, 2, 3, 4};
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_err !== 1'b1 || imem_en !== 1'b1 || imem_addr !== '0) begin
            errors++;
            $display("FAIL oor: err=%b en=%b addr=%0d, required 1 1 0", fetch_err, imem_en, imem_addr);
        end
        drain(20);
        tick(); tick(); @(negedge clk);
        checks++;
        if (halted !== 1'b1 || fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_sticky: halted=%b err=%b, required 1 1", halted, fetch_err);
        end
    endtask

    task automatic test_reset_mid;
        tick(); redirect_valid = 1'b1; redirect_pc = 0; out_ready = 1'b0;
        tick(); redirect_valid = 1'b0;
        tick(); tick(); tick(); @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== '0 || imem_en !== 1'b0) begin
            errors++;
            $display("FAIL rm_full: valid=%b pc=%0d en=%b, required 1 0 0", out_valid, out_pc, imem_en);
        end
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || fetch_err !== 1'b0 || halted !== 1'b0 || imem_en !== 1'b1 || imem_addr !== '0) begin
            errors++;
            $display("FAIL rm_clear: valid=%b err=%b halted=%b en=%b addr=%0d, required 0 0 0 1 0",
                     out_valid, fetch_err, halted, imem_en, imem_addr);
        end
        exp_q = '{0, 1, 2, 3, 4};
        out_ready = 1'b1;
        drain(20);
        tick(); tick(); @(negedge clk);
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL rm_halt: halted=%b, required 1", halted);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = mk(i);
        mem[4] = '0;
        mem[8] = '0;
        mem[8][5*SLOT_W +: SLOT_W] = 32'h4900_0000;
        mem[9] = '0;
        test_reset();
        test_latency_halt();
        test_slot_mask();
        test_backpressure();
        test_redirect_pending();
        test_wrap_err();
        test_reset_mid();
        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_left: %0d expected bundles never seen, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
